key_debounce: RTL and testbench

Input-side conditioner for the calendar front panel. It takes the raw active-low push keys (`key[1:0]`: digit select / value increment), synchronises and debounces them, and emits one-cycle press, release and auto-repeat strobes to the time/date/alarm setting logic. It sits between the board key pins and the mode/edit controller that `sw[3:0]` selects. It is the receiving end of the key stimulus the top-level bench drives; held presses are typically 10 ms at 100 MHz.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce_ch.sv | 117 +++++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and 100 MHz timing defaults for the front-panel key conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  localparam int DEF_DB_CYCLES     = 500_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 20_000_000;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and auto-repeat timer.
//   state      | meaning
//   IDLE       | debounced released, level 0
//   PRESS_DB   | counting toward pressed
//   HELD       | debounced pressed, level 1, repeat timer running
//   RELEASE_DB | counting toward released, repeat timer still running
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam int RP_W = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_LD  = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REPEAT_LD = RP_W'(REPEAT_CYCLES - 1);

  logic [1:0]      sync;
  logic            s;
  key_state_t      state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_nxt;
  logic [RP_W-1:0] rp_cnt, rp_nxt;
  logic            level_nxt, press_nxt, release_nxt, repeat_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], key};
  end

  assign s = ~sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      rp_cnt      <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_nxt;
      rp_cnt      <= rp_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_repeat  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_nxt      = '0;
    rp_nxt      = '0;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;

    // Repeat timer keeps running through release bounces so the cadence is not restarted.
    if (state == HELD || state == RELEASE_DB) begin
      if (rp_cnt == '0) begin
        repeat_nxt = 1'b1;
        rp_nxt     = REPEAT_LD;
      end else begin
        rp_nxt = rp_cnt - RP_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (s) state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = HELD;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          rp_nxt    = HOLD_LD;
        end else begin
          db_nxt = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!s) state_nxt = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (s) begin
          state_nxt = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
          repeat_nxt  = 1'b0;
          rp_nxt      = '0;
        end else begin
          db_nxt = db_cnt + DB_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/key_debounce.sv
// Front-panel key conditioner: NUM_KEYS independent debounced channels with
// press, release and auto-repeat strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 2,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed plus random bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int DB   = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key = 2'b11;
  logic [1:0] key_level, key_press, key_release, key_repeat;

  key_debounce #(
    .NUM_KEYS(2), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: raw seen two edges late; level flips after DB+1 consecutive disagreeing
  // samples; repeats at press+HOLD+n*REP while pressed, never on the release cycle.
  logic [1:0] p1 = 2'b11, p2 = 2'b11;
  logic [1:0] m_level = 2'b00, m_press = 2'b00, m_rel = 2'b00, m_rep = 2'b00;
  int run[2] = '{0, 0};
  int press_at[2] = '{0, 0};
  int cyc = 0;
  int n_press[2], n_rel[2], n_rep[2];

  task automatic model_edge(input logic [1:0] kv);
    logic was, s;
    int age;
    cyc++;
    m_press = 2'b00; m_rel = 2'b00; m_rep = 2'b00;
    if (!rst) begin
      p1 = 2'b11; p2 = 2'b11; m_level = 2'b00; run = '{0, 0};
    end else begin
      for (int c = 0; c < 2; c++) begin
        was = m_level[c];
        s   = ~p2[c];
        if (s != was) run[c]++;
        else          run[c] = 0;
        if (run[c] == DB + 1) begin
          run[c] = 0;
          m_level[c] = s;
          if (s) begin m_press[c] = 1'b1; press_at[c] = cyc; end
          else   m_rel[c] = 1'b1;
        end
        age = cyc - press_at[c];
        if (was && !m_rel[c] && age >= HOLD && ((age - HOLD) % REP) == 0) m_rep[c] = 1'b1;
      end
      p2 = p1;
      p1 = kv;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] kv);
    key = kv;
    @(posedge clk);
    model_edge(kv);
    #1;
    chk("level", key_level, m_level);
    chk("press", key_press, m_press);
    chk("release", key_release, m_rel);
    chk("repeat", key_repeat, m_rep);
    for (int c = 0; c < 2; c++) begin
      n_press[c] += int'(key_press[c]);
      n_rel[c]   += int'(key_release[c]);
      n_rep[c]   += int'(key_repeat[c]);
    end
  endtask

  task automatic hold(input logic [1:0] kv, input int n);
    for (int i = 0; i < n; i++) step(kv);
  endtask

  task automatic clr_counts();
    n_press = '{0, 0}; n_rel = '{0, 0}; n_rep = '{0, 0};
  endtask

  initial begin
    clr_counts();
    // Reset held with keys released
    hold(2'b11, 50);
    rst = 1'b1;
    hold(2'b11, 20);
    chk_n("idle_strobes", n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_rep[0] + n_rep[1], 0);

    // key0 pressed 30 cycles
    clr_counts();
    hold(2'b10, 30);
    hold(2'b11, 20);
    chk_n("k0_press_cnt", n_press[0], 1);
    chk_n("k0_release_cnt", n_rel[0], 1);

    // key1 bounces then settles
    clr_counts();
    hold(2'b01, 3); hold(2'b11, 3);
    hold(2'b01, 5); hold(2'b11, 5);
    hold(2'b01, 7); hold(2'b11, 2);
    chk_n("bounce_no_press", n_press[1], 0);
    hold(2'b01, 60);
    hold(2'b11, 20);
    chk_n("k1_press_cnt", n_press[1], 1);
    chk_n("k1_release_cnt", n_rel[1], 1);

    // both pressed together, staggered release
    clr_counts();
    hold(2'b00, 30);
    hold(2'b01, 4);
    hold(2'b11, 20);
    chk_n("both_press0", n_press[0], 1);
    chk_n("both_press1", n_press[1], 1);
    chk_n("both_rel1", n_rel[1], 1);

    // key0 held with short release glitch
    clr_counts();
    hold(2'b10, 30);
    hold(2'b11, 4);
    hold(2'b10, 6);
    chk_n("glitch_no_release", n_rel[0], 0);
    hold(2'b11, 20);
    chk_n("glitch_release", n_rel[0], 1);

    // reset pulse while key0 is held
    clr_counts();
    hold(2'b10, 15);
    #2 rst = 1'b0;
    #1;
    chk("async_level", key_level, 2'b00);
    chk("async_press", key_press, 2'b00);
    hold(2'b10, 3);
    rst = 1'b1;
    clr_counts();
    hold(2'b10, 20);
    chk_n("post_rst_press", n_press[0], 1);
    hold(2'b11, 15);

    // random segments on both keys
    for (int i = 0; i < 40; i++) begin
      logic [1:0] kv;
      kv = 2'($urandom_range(0, 3));
      hold(kv, int'($urandom_range(1, 14)));
    end
    hold(2'b11, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
